// File: rtl/fe_fifo_reader_if.sv
// Interface bundle for fe_fifo_reader: FWFT FIFO read port, readout control and byte stream.
// The design attaches to the slave modport; the master modport is the environment side.
interface fe_fifo_reader_if #(
  parameter int pTIMESTAMP_FULL_WIDTH = 16,
  parameter int pCOUNT_WIDTH          = 24
);
  logic                             I_fifo_empty;
  logic [1:0]                       I_fifo_command;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] I_fifo_time;
  logic [7:0]                       I_fifo_data;
  logic                             O_fifo_rd;
  logic                             I_enable;
  logic                             I_flush;
  logic [7:0]                       O_data;
  logic                             O_data_valid;
  logic                             I_data_ready;
  logic [pCOUNT_WIDTH-1:0]          O_bytes_read;
  logic                             O_busy;

  modport master (
    output I_fifo_empty, I_fifo_command, I_fifo_time, I_fifo_data,
    output I_enable, I_flush, I_data_ready,
    input  O_fifo_rd, O_data, O_data_valid, O_bytes_read, O_busy
  );

  modport slave (
    input  I_fifo_empty, I_fifo_command, I_fifo_time, I_fifo_data,
    input  I_enable, I_flush, I_data_ready,
    output O_fifo_rd, O_data, O_data_valid, O_bytes_read, O_busy
  );
endinterface

// File: rtl/fe_fifo_reader.sv
// Front-end capture FIFO reader: pops {cmd, time, data} entries from an FWFT FIFO
// and serializes each into a header byte plus 1 or 2 payload bytes on a valid/ready stream.
//
// state | meaning
// IDLE  | no entry held; pops the head entry when enabled
// HDR   | presenting the header byte of the held entry
// B1    | presenting data byte (DATA/STAT) or time[15:8] (TIME)
// B2    | presenting time[7:0] (TIME only)
module fe_fifo_reader #(
  parameter int pTIMESTAMP_FULL_WIDTH  = 16,
  parameter int pTIMESTAMP_SHORT_WIDTH = 3,
  parameter int pCOUNT_WIDTH           = 24
) (
  input  logic            cwusb_clk,
  input  logic            reset_i,
  fe_fifo_reader_if.slave bus
);

  localparam logic [1:0] CMD_DATA = 2'd0;
  localparam logic [1:0] CMD_STAT = 2'd1;
  localparam logic [1:0] CMD_TIME = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_B1   = 2'd2,
    S_B2   = 2'd3
  } state_t;

  state_t                           state_q, state_d;
  logic [1:0]                       cmd_q, cmd_d;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] time_q, time_d;
  logic [7:0]                       data_q, data_d;
  logic [pCOUNT_WIDTH-1:0]          count_q, count_d;

  logic       fifo_rd;
  logic       valid;
  logic       accept;
  logic [7:0] hdr_byte;
  logic [7:0] byte_out;

  // Only DATA/STAT headers carry the short timestamp; TIME and unknown carry the command alone.
  always_comb begin
    hdr_byte = {cmd_q, 6'b0};
    if (cmd_q == CMD_DATA || cmd_q == CMD_STAT) begin
      hdr_byte = {cmd_q, 6'b0} | 8'(time_q[pTIMESTAMP_SHORT_WIDTH-1:0]);
    end
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    time_d   = time_q;
    data_d   = data_q;
    count_d  = count_q;
    fifo_rd  = 1'b0;
    byte_out = 8'h00;
    valid    = (state_q != S_IDLE);
    accept   = valid && bus.I_data_ready;

    unique case (state_q)
      S_IDLE: begin
        if (bus.I_enable && !bus.I_fifo_empty && !bus.I_flush) begin
          fifo_rd = 1'b1;
          cmd_d   = bus.I_fifo_command;
          time_d  = bus.I_fifo_time;
          data_d  = bus.I_fifo_data;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        byte_out = hdr_byte;
        if (accept) begin
          state_d = (cmd_q == 2'd3) ? S_IDLE : S_B1;
        end
      end
      S_B1: begin
        byte_out = (cmd_q == CMD_TIME) ? time_q[pTIMESTAMP_FULL_WIDTH-1 -: 8] : data_q;
        if (accept) begin
          state_d = (cmd_q == CMD_TIME) ? S_B2 : S_IDLE;
        end
      end
      S_B2: begin
        byte_out = time_q[7:0];
        if (accept) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept && count_q != {pCOUNT_WIDTH{1'b1}}) begin
      count_d = count_q + 1'b1;
    end

    // Flush overrides every other update, including an accept in the same cycle.
    if (bus.I_flush) begin
      state_d = S_IDLE;
      count_d = '0;
    end
  end

  always_ff @(posedge cwusb_clk) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      time_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      time_q  <= time_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign bus.O_fifo_rd    = fifo_rd;
  assign bus.O_data       = byte_out;
  assign bus.O_data_valid = valid;
  assign bus.O_bytes_read = count_q;
  assign bus.O_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fe_fifo_reader.sv
// Directed self-checking bench for fe_fifo_reader: byte sequences, pops, backpressure,
// flush, enable gating and byte counting.
module tb_fe_fifo_reader;

  logic cwusb_clk = 1'b0;
  logic reset_i   = 1'b1;
  int   checks    = 0;
  int   errors    = 0;
  int   pops      = 0;
  int   pop_base  = 0;

  fe_fifo_reader_if #(.pTIMESTAMP_FULL_WIDTH(16), .pCOUNT_WIDTH(24)) bus ();

  fe_fifo_reader #(
    .pTIMESTAMP_FULL_WIDTH (16),
    .pTIMESTAMP_SHORT_WIDTH(3),
    .pCOUNT_WIDTH          (24)
  ) dut (
    .cwusb_clk(cwusb_clk),
    .reset_i  (reset_i),
    .bus      (bus)
  );

  always #5 cwusb_clk = ~cwusb_clk;

  always @(posedge cwusb_clk) begin
    if (bus.O_fifo_rd === 1'b1) pops <= pops + 1;
  end

  task automatic step();
    @(posedge cwusb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an entry at the FIFO head, expect the pop this cycle, then the FIFO goes empty.
  task automatic push(input string tag, input logic [1:0] cmd, input logic [15:0] tm,
                      input logic [7:0] dat);
    bus.I_fifo_command = cmd;
    bus.I_fifo_time    = tm;
    bus.I_fifo_data    = dat;
    bus.I_fifo_empty   = 1'b0;
    #1;
    chk({tag, "_pop"}, 32'(bus.O_fifo_rd), 32'd1);
    step();
    bus.I_fifo_empty = 1'b1;
    #1;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] b);
    chk({tag, "_valid"}, 32'(bus.O_data_valid), 32'd1);
    chk({tag, "_data"},  32'(bus.O_data), 32'(b));
    chk({tag, "_norp"},  32'(bus.O_fifo_rd), 32'd0);
    step();
  endtask

  task automatic expect_idle(input string tag, input logic [23:0] cnt);
    chk({tag, "_valid"}, 32'(bus.O_data_valid), 32'd0);
    chk({tag, "_busy"},  32'(bus.O_busy), 32'd0);
    chk({tag, "_count"}, 32'(bus.O_bytes_read), 32'(cnt));
  endtask

  task automatic do_flush(input string tag);
    bus.I_flush = 1'b1;
    #1;
    chk({tag, "_norp"}, 32'(bus.O_fifo_rd), 32'd0);
    step();
    bus.I_flush = 1'b0;
    #1;
    expect_idle(tag, 24'd0);
  endtask

  initial begin
    bus.I_fifo_empty   = 1'b1;
    bus.I_fifo_command = 2'd0;
    bus.I_fifo_time    = 16'h0000;
    bus.I_fifo_data    = 8'h00;
    bus.I_enable       = 1'b0;
    bus.I_flush        = 1'b0;
    bus.I_data_ready   = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    #1;
    expect_idle("rst", 24'd0);
    chk("rst_data", 32'(bus.O_data), 32'h0);
    chk("rst_rd", 32'(bus.O_fifo_rd), 32'd0);

    // DATA entry: header 0x05, data 0xA7
    bus.I_enable = 1'b1;
    pop_base = pops;
    push("d1", 2'd0, 16'h0005, 8'hA7);
    expect_byte("d1_hdr", 8'h05);
    expect_byte("d1_b1", 8'hA7);
    expect_idle("d1_end", 24'd2);
    chk("d1_pops", 32'(pops - pop_base), 32'd1);

    // TIME entry after flush: 0x80, 0x12, 0x34
    do_flush("fl1");
    pop_base = pops;
    push("t1", 2'd2, 16'h1234, 8'h00);
    expect_byte("t1_hdr", 8'h80);
    expect_byte("t1_b1", 8'h12);
    expect_byte("t1_b2", 8'h34);
    expect_idle("t1_end", 24'd3);
    chk("t1_pops", 32'(pops - pop_base), 32'd1);

    // Backpressure on the header of DATA 0x3C while another entry waits
    do_flush("fl2");
    pop_base = pops;
    bus.I_data_ready = 1'b0;
    push("bp", 2'd0, 16'h0006, 8'h3C);
    bus.I_fifo_empty   = 1'b0;
    bus.I_fifo_command = 2'd1;
    bus.I_fifo_data    = 8'hEE;
    #1;
    for (int i = 0; i < 4; i++) begin
      expect_byte("bp_hold", 8'h06);
    end
    chk("bp_count_held", 32'(bus.O_bytes_read), 32'd0);
    bus.I_data_ready = 1'b1;
    expect_byte("bp_hdr", 8'h06);
    bus.I_fifo_empty = 1'b1;
    #1;
    expect_byte("bp_b1", 8'h3C);
    expect_idle("bp_end", 24'd2);
    chk("bp_pops", 32'(pops - pop_base), 32'd1);

    // Flush mid-TIME after the header is accepted
    push("fm", 2'd2, 16'hABCD, 8'h00);
    expect_byte("fm_hdr", 8'h80);
    do_flush("fm_flush");
    push("fm2", 2'd1, 16'h0003, 8'h5A);
    expect_byte("fm2_hdr", 8'h43);
    expect_byte("fm2_b1", 8'h5A);
    expect_idle("fm2_end", 24'd2);

    // Enable low with a non-empty FIFO: no pop until enabled
    bus.I_enable       = 1'b0;
    bus.I_fifo_empty   = 1'b0;
    bus.I_fifo_command = 2'd0;
    bus.I_fifo_time    = 16'h0007;
    bus.I_fifo_data    = 8'h11;
    pop_base = pops;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("en0_norp", 32'(bus.O_fifo_rd), 32'd0);
      chk("en0_busy", 32'(bus.O_busy), 32'd0);
      step();
    end
    chk("en0_pops", 32'(pops - pop_base), 32'd0);
    bus.I_enable = 1'b1;
    push("en1", 2'd0, 16'h0007, 8'h11);
    expect_byte("en1_hdr", 8'h07);
    expect_byte("en1_b1", 8'h11);
    expect_idle("en1_end", 24'd4);

    // Back-to-back DATA, TIME, STAT with ready held high
    do_flush("fl3");
    pop_base = pops;
    push("bb_d", 2'd0, 16'h0001, 8'h22);
    expect_byte("bb_d_hdr", 8'h01);
    expect_byte("bb_d_b1", 8'h22);
    push("bb_t", 2'd2, 16'h0F0E, 8'h00);
    expect_byte("bb_t_hdr", 8'h80);
    expect_byte("bb_t_b1", 8'h0F);
    expect_byte("bb_t_b2", 8'h0E);
    push("bb_s", 2'd1, 16'h0002, 8'h33);
    expect_byte("bb_s_hdr", 8'h42);
    expect_byte("bb_s_b1", 8'h33);
    expect_idle("bb_end", 24'd7);
    chk("bb_pops", 32'(pops - pop_base), 32'd3);

    // Unknown command: single 0xC0 byte, no timestamp bits
    push("unk", 2'd3, 16'h0007, 8'h99);
    expect_byte("unk_hdr", 8'hC0);
    expect_idle("unk_end", 24'd8);

    // Enable dropped mid-entry: remaining bytes still emitted, then no new pop
    pop_base = pops;
    push("ed", 2'd2, 16'h5566, 8'h00);
    bus.I_enable     = 1'b0;
    bus.I_fifo_empty = 1'b0;
    #1;
    expect_byte("ed_hdr", 8'h80);
    expect_byte("ed_b1", 8'h55);
    expect_byte("ed_b2", 8'h66);
    expect_idle("ed_end", 24'd11);
    chk("ed_norp", 32'(bus.O_fifo_rd), 32'd0);
    step();
    chk("ed_pops", 32'(pops - pop_base), 32'd1);
    bus.I_fifo_empty = 1'b1;
    bus.I_enable     = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
